conv_window_streamer: RTL



---
 rtl/conv_window_if.sv | 33 +++
 rtl/conv_window_streamer.sv | 107 ++++++++++
 2 files changed

// File: rtl/conv_window_if.sv
// Pixel-in / window-out handshake bundle for conv_window_streamer.
// master = stream source and window sink, slave = the streamer.
interface conv_window_if #(
  parameter int DATA_W = 16,
  parameter int H      = 256,
  parameter int W      = 256
);
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  logic [DATA_W-1:0]   pix_in;
  logic                in_valid;
  logic                in_ready;
  logic [9*DATA_W-1:0] win_out;
  logic                out_valid;
  logic                out_ready;
  logic [RW-1:0]       out_row;
  logic [CW-1:0]       out_col;
  logic                out_first;
  logic                out_last;

  modport master (
    output pix_in, in_valid, out_ready,
    input  in_ready, win_out, out_valid,
    input  out_row, out_col, out_first, out_last
  );

  modport slave (
    input  pix_in, in_valid, out_ready,
    output in_ready, win_out, out_valid,
    output out_row, out_col, out_first, out_last
  );
endinterface

// File: rtl/conv_window_streamer.sv
// Raster pixel stream to zero-padded 3x3 windows, one window per pixel.
// Sweeps an (H+1)x(W+1) virtual grid; the extra row/column inject zeros.
module conv_window_streamer #(
  parameter int DATA_W = 16,
  parameter int H      = 256,
  parameter int W      = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_window_if.slave  s
);
  localparam int RW  = $clog2(H);
  localparam int CW  = $clog2(W);
  localparam int VRW = $clog2(H + 1);
  localparam int VCW = $clog2(W + 1);
  localparam logic [VRW-1:0] HL = VRW'(H);
  localparam logic [VCW-1:0] WL = VCW'(W);

  typedef logic [DATA_W-1:0] px_t;

  logic [VRW-1:0] vr;
  logic [VCW-1:0] vc;
  logic           run;
  logic [CW-1:0]  idx;
  logic           real_s;
  logic           slot_free;
  logic           adv;
  logic           emit;

  px_t lb0 [W];
  px_t lb1 [W];
  px_t c1 [3];
  px_t c2 [3];
  px_t nc [3];
  px_t wn [9];

  assign real_s    = (vr < HL) && (vc < WL);
  assign slot_free = !s.out_valid || s.out_ready;
  assign s.in_ready = run && slot_free && real_s;
  assign adv  = run && slot_free && (!real_s || s.in_valid);
  assign emit = (vr != '0) && (vc != '0);
  assign idx  = CW'(vc);

  // c1/c2 hold the two older columns; nc is the column entering now
  always_comb begin
    nc = '{default: '0};
    wn = '{default: '0};
    if (vc < WL) begin
      nc[0] = lb1[idx];
      nc[1] = lb0[idx];
    end
    if (real_s) nc[2] = s.pix_in;
    for (int m = 0; m < 3; m++) begin
      if (!(m == 0 && vr == VRW'(1))) begin
        if (vc != VCW'(1)) wn[3*m] = c1[m];
        wn[3*m+1] = c2[m];
        wn[3*m+2] = nc[m];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv && (vc < WL)) begin
      lb1[idx] <= lb0[idx];
      lb0[idx] <= nc[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      vr          <= '0;
      vc          <= '0;
      c1          <= '{default: '0};
      c2          <= '{default: '0};
      s.out_valid <= 1'b0;
      s.win_out   <= '0;
      s.out_row   <= '0;
      s.out_col   <= '0;
      s.out_first <= 1'b0;
      s.out_last  <= 1'b0;
    end else begin
      run <= 1'b1;
      if (adv) begin
        c1 <= c2;
        c2 <= nc;
        if (vc == WL) begin
          vc <= '0;
          vr <= (vr == HL) ? '0 : vr + VRW'(1);
        end else begin
          vc <= vc + VCW'(1);
        end
        s.out_valid <= emit;
        if (emit) begin
          for (int i = 0; i < 9; i++)
            s.win_out[DATA_W*i +: DATA_W] <= wn[i];
          s.out_row   <= RW'(vr - VRW'(1));
          s.out_col   <= CW'(vc - VCW'(1));
          s.out_first <= (vr == VRW'(1)) && (vc == VCW'(1));
          s.out_last  <= (vr == HL) && (vc == WL);
        end
      end else if (s.out_ready) begin
        s.out_valid <= 1'b0;
      end
    end
  end
endmodule
